// File: rtl/array_addition.sv
// Registered element-wise adder for two packed unsigned arrays, with per-lane carry flags.
// Optional saturating lanes when ARRAY_ADD_SAT_EN is defined; wrap-around otherwise.
module array_addition #(
  parameter int ELEM_W = 3,
  parameter int N_ELEM = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [N_ELEM*ELEM_W-1:0]   flatArray1,
  input  logic [N_ELEM*ELEM_W-1:0]   flatArray2,
  output logic                       out_valid,
  output logic [N_ELEM*ELEM_W-1:0]   flatResult,
  output logic [N_ELEM-1:0]          overflow
);

  logic [N_ELEM*ELEM_W-1:0] w_res;
  logic [N_ELEM-1:0]        w_ovf;

  logic                     r_valid;
  logic [N_ELEM*ELEM_W-1:0] r_res;
  logic [N_ELEM-1:0]        r_ovf;

  // Each lane is its own ELEM_W+1 bit add, so no carry can leak into a neighbour.
  for (genvar g = 0; g < N_ELEM; g++) begin : g_lane
    logic [ELEM_W:0] w_full;

    assign w_full   = {1'b0, flatArray1[g*ELEM_W +: ELEM_W]}
                    + {1'b0, flatArray2[g*ELEM_W +: ELEM_W]};
    assign w_ovf[g] = w_full[ELEM_W];

`ifdef ARRAY_ADD_SAT_EN
    assign w_res[g*ELEM_W +: ELEM_W] = w_full[ELEM_W] ? {ELEM_W{1'b1}}
                                                      : w_full[ELEM_W-1:0];
`else
    assign w_res[g*ELEM_W +: ELEM_W] = w_full[ELEM_W-1:0];
`endif
  end

  // Data registers hold their last sum while idle; only the strobe drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_ovf   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_res;
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid  = r_valid;
  assign flatResult = r_res;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_array_addition.sv
// Scoreboard bench for array_addition: driver pushes model results, monitor pops on out_valid.
// Honours ARRAY_ADD_SAT_EN in its reference model to match the build under test.
module tb_array_addition;

  localparam int EW = 3;
  localparam int NE = 9;
  localparam int W  = EW * NE;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] flatArray1 = '0;
  logic [W-1:0] flatArray2 = '0;
  logic         out_valid;
  logic [W-1:0] flatResult;
  logic [NE-1:0] overflow;

  array_addition #(.ELEM_W(EW), .N_ELEM(NE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .flatArray1 (flatArray1),
    .flatArray2 (flatArray2),
    .out_valid  (out_valid),
    .flatResult (flatResult),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  logic [W+NE-1:0] exp_q[$];
  logic [W-1:0]    last_res = '0;
  logic [NE-1:0]   last_ovf = '0;
  int              n_vec = 0;
  int              n_err = 0;

  // Reference: plain integer arithmetic per element.
  function automatic logic [W+NE-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]  r;
    logic [NE-1:0] o;
    int            lim;
    int            s;
    lim = 1 << EW;
    r = '0;
    o = '0;
    for (int i = 0; i < NE; i++) begin
      s = int'(a[i*EW +: EW]) + int'(b[i*EW +: EW]);
      o[i] = (s >= lim);
`ifdef ARRAY_ADD_SAT_EN
      if (s >= lim) s = lim - 1;
`else
      s = s % lim;
`endif
      r[i*EW +: EW] = EW'(s);
    end
    return {r, o};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst        = r;
    in_valid   = v;
    flatArray1 = a;
    flatArray2 = b;
    if (r) begin
      exp_q.delete();
      last_res = '0;
      last_ovf = '0;
    end else if (v) begin
      exp_q.push_back(model(a, b));
    end
  endtask

  // Monitor: an entry in the queue means the edge just passed must have produced it.
  initial begin
    logic [W+NE-1:0] e;
    logic            exp_v;
    forever begin
      @(posedge clk);
      #1;
      exp_v = (exp_q.size() > 0);
      if (exp_v) begin
        e = exp_q.pop_front();
        last_res = e[W+NE-1:NE];
        last_ovf = e[NE-1:0];
      end
      n_vec++;
      if (out_valid !== exp_v) begin
        n_err++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_v, $time);
      end
      n_vec++;
      if (flatResult !== last_res) begin
        n_err++;
        $display("FAIL flatResult: got %h expected %h at %0t", flatResult, last_res, $time);
      end
      n_vec++;
      if (overflow !== last_ovf) begin
        n_err++;
        $display("FAIL overflow: got %h expected %h at %0t", overflow, last_ovf, $time);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         r;
    logic         v;
    // Reset for two cycles.
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    // Directed vectors back to back, then idle hold.
    drive(1'b0, 1'b1, 27'h2345678, 27'h2345678);
    drive(1'b0, 1'b1, 27'h7FFFFFF, 27'h0249249);
    drive(1'b0, 1'b1, 27'h0000000, 27'h5555555);
    drive(1'b0, 1'b1, 27'h2345678, 27'h2345678);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 27'h7FFFFFF, 27'h7FFFFFF);
    // Reset wins over a same-cycle valid, then three back-to-back results.
    drive(1'b1, 1'b1, 27'h7FFFFFF, 27'h7FFFFFF);
    drive(1'b0, 1'b1, 27'h0123456, 27'h7654321);
    drive(1'b0, 1'b1, 27'h7FFFFFF, 27'h7FFFFFF);
    drive(1'b0, 1'b1, 27'h1B6DB6D, 27'h0924924);
    // Reset mid-stream, then resume.
    drive(1'b0, 1'b1, 27'h3FFFFFF, 27'h1000001);
    drive(1'b1, 1'b1, 27'h5555555, 27'h2AAAAAA);
    drive(1'b0, 1'b1, 27'h5555555, 27'h2AAAAAA);
    drive(1'b0, 1'b0, '0, '0);
    // Randomized traffic with valid gaps and occasional resets.
    for (int i = 0; i < 400; i++) begin
      a = W'($urandom());
      b = W'($urandom());
      if ($urandom_range(0, 9) == 0) a = '1;
      if ($urandom_range(0, 9) == 0) b = '0;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      drive(r, v, a, b);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never appeared, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
